wb_stage_buf: RTL and testbench

//  Parametrised M->W pipeline stage: a 2-entry elastic (skid) buffer with valid/ready handshake on both sides.

---
 rtl/wb_stage_buf.sv | 143 ++++++++++++++
 tb/tb_wb_stage_buf.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_buf.sv
// M->W write-back stage: 2-entry skid buffer with WD select at capture,
// GRF write port, W-stage forwarding bus and a retired-instruction counter.
module wb_stage_buf #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int SELW     = 2,
  parameter int N_SRC    = 4,
  parameter int LINK_OFF = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [SELW-1:0]  m_wdsel,
  input  logic [DW-1:0]    m_memory,
  input  logic [DW-1:0]    m_result,
  input  logic [DW-1:0]    m_pc,
  input  logic [DW-1:0]    m_md,
  input  logic [DW-1:0]    m_op,
  input  logic [AW-1:0]    m_a3,
  input  logic             m_regwrite,
  input  logic             w_ready,
  output logic             w_valid,
  output logic [DW-1:0]    w_wd,
  output logic [AW-1:0]    w_a3,
  output logic             w_regwrite,
  output logic [DW-1:0]    w_pc,
  output logic [DW-1:0]    w_op,
  output logic [DW-1:0]    fwd_data,
  output logic [AW-1:0]    fwd_a3,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef struct packed {
    logic [DW-1:0] wd;
    logic [AW-1:0] a3;
    logic          rw;
    logic [DW-1:0] pc;
    logic [DW-1:0] op;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } occ_t;

  occ_t          st, st_n;
  ent_t          head, skid, cap;
  logic [DW-1:0] sel_wd;
  logic          push, pop, h_v;
  logic          ld_head, ld_skid, mv;

  always_comb begin
    sel_wd = '0;
    if (32'(m_wdsel) < N_SRC) begin
      unique case (m_wdsel)
        SELW'(0): sel_wd = m_memory;
        SELW'(1): sel_wd = m_result;
        SELW'(2): sel_wd = m_pc + DW'(LINK_OFF);
        SELW'(3): sel_wd = m_md;
        default:  sel_wd = '0;
      endcase
    end
  end

  always_comb begin
    cap    = '0;
    cap.wd = sel_wd;
    cap.a3 = m_a3;
    cap.rw = m_regwrite;
    cap.pc = m_pc;
    cap.op = m_op;
  end

  assign h_v     = (st != EMPTY);
  assign m_ready = (st != FULL);
  assign push    = m_valid & m_ready;
  assign pop     = h_v & w_ready;

  always_comb begin
    st_n    = st;
    ld_head = 1'b0;
    ld_skid = 1'b0;
    mv      = 1'b0;
    if (req) begin
      st_n = EMPTY;
    end else begin
      unique case (st)
        EMPTY: begin
          if (push) begin
            st_n    = ONE;
            ld_head = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            ld_head = 1'b1;
          end else if (push) begin
            st_n    = FULL;
            ld_skid = 1'b1;
          end else if (pop) begin
            st_n = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            st_n = ONE;
            mv   = 1'b1;
          end
        end
        default: st_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= EMPTY;
      head       <= '0;
      skid       <= '0;
      retire_cnt <= '0;
    end else begin
      st <= st_n;
      if (ld_head) head <= cap;
      else if (mv) head <= skid;
      if (ld_skid) skid <= cap;
      if (pop && !req) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign w_valid    = h_v;
  assign w_wd       = head.wd;
  assign w_a3       = head.a3;
  assign w_pc       = head.pc;
  assign w_op       = head.op;
  assign w_regwrite = h_v & head.rw & (head.a3 != '0);
  assign fwd_data   = head.wd;
  assign fwd_a3     = w_regwrite ? head.a3 : '0;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: directed scenarios plus a random run
// against a queue-based reference of the write-back buffer.
module tb_wb_stage_buf;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [DW-1:0] wd;
    logic [AW-1:0] a3;
    logic          rw;
    logic [DW-1:0] pc;
    logic [DW-1:0] op;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          m_valid;
  logic          m_ready;
  logic [1:0]    m_wdsel;
  logic [DW-1:0] m_memory, m_result, m_pc, m_md, m_op;
  logic [AW-1:0] m_a3;
  logic          m_regwrite;
  logic          w_ready;
  logic          w_valid;
  logic [DW-1:0] w_wd;
  logic [AW-1:0] w_a3;
  logic          w_regwrite;
  logic [DW-1:0] w_pc, w_op, fwd_data;
  logic [AW-1:0] fwd_a3;
  logic [31:0]   retire_cnt;

  ent_t        q[$];
  logic [31:0] cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_stage_buf dut (
    .clk(clk), .reset(reset), .req(req),
    .m_valid(m_valid), .m_ready(m_ready), .m_wdsel(m_wdsel),
    .m_memory(m_memory), .m_result(m_result), .m_pc(m_pc),
    .m_md(m_md), .m_op(m_op), .m_a3(m_a3), .m_regwrite(m_regwrite),
    .w_ready(w_ready), .w_valid(w_valid), .w_wd(w_wd), .w_a3(w_a3),
    .w_regwrite(w_regwrite), .w_pc(w_pc), .w_op(w_op),
    .fwd_data(fwd_data), .fwd_a3(fwd_a3), .retire_cnt(retire_cnt)
  );

  function automatic logic [DW-1:0] ref_wd(input logic [1:0] s);
    case (s)
      2'd0: return m_memory;
      2'd1: return m_result;
      2'd2: return m_pc + 32'd8;
      default: return m_md;
    endcase
  endfunction

  task automatic rand_in();
    m_wdsel    = 2'($urandom_range(0, 3));
    m_memory   = $urandom;
    m_result   = $urandom;
    m_pc       = $urandom;
    m_md       = $urandom;
    m_op       = $urandom;
    m_a3       = 5'($urandom);
    m_regwrite = 1'($urandom);
  endtask

  task automatic tick();
    ent_t e;
    bit   do_pop, do_push;
    @(posedge clk);
    if (req) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && w_ready;
      do_push = m_valid && (q.size() < 2);
      e.wd = ref_wd(m_wdsel);
      e.a3 = m_a3;
      e.rw = m_regwrite;
      e.pc = m_pc;
      e.op = m_op;
      if (do_pop) begin
        void'(q.pop_front());
        cnt = cnt + 1;
      end
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset_state();
    reset = 1'b0; req = 0; m_valid = 0; w_ready = 0;
    rand_in();
    q.delete(); cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (w_valid !== 1'b0 || m_ready !== 1'b1 || w_regwrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl: w_valid=%b m_ready=%b w_rw=%b need 0 1 0",
               w_valid, m_ready, w_regwrite);
    end
    checks++;
    if (w_wd !== 32'd0 || fwd_a3 !== 5'd0 || retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_data: w_wd=%h fwd_a3=%0d cnt=%0d need 0 0 0",
               w_wd, fwd_a3, retire_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_link();
    w_ready = 1; m_valid = 1;
    rand_in();
    m_wdsel = 2; m_pc = 32'h3000; m_a3 = 31; m_regwrite = 1;
    tick();
    m_valid = 0;
    checks++;
    if (w_valid !== 1'b1 || w_wd !== 32'h3008 || fwd_data !== 32'h3008) begin
      errors++;
      $display("FAIL link_wd: valid=%b wd=%h fwd=%h need 1 3008 3008",
               w_valid, w_wd, fwd_data);
    end
    checks++;
    if (w_regwrite !== 1'b1 || fwd_a3 !== 5'd31 || w_a3 !== 5'd31) begin
      errors++;
      $display("FAIL link_a3: rw=%b fwd_a3=%0d a3=%0d need 1 31 31",
               w_regwrite, fwd_a3, w_a3);
    end
    tick();
    checks++;
    if (retire_cnt !== 32'd1 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL link_cnt: cnt=%0d valid=%b need 1 0", retire_cnt, w_valid);
    end
  endtask

  task automatic test_order();
    logic [DW-1:0] pa, pb;
    w_ready = 0; m_valid = 1;
    rand_in(); pa = m_pc;
    tick();
    rand_in(); pb = m_pc;
    tick();
    m_valid = 0;
    checks++;
    if (m_ready !== 1'b0 || w_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_ready: m_ready=%b w_valid=%b need 0 1", m_ready, w_valid);
    end
    w_ready = 1;
    checks++;
    if (w_pc !== pa) begin
      errors++;
      $display("FAIL order_a: w_pc=%h need %h", w_pc, pa);
    end
    tick();
    checks++;
    if (w_valid !== 1'b1 || w_pc !== pb || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL order_b: valid=%b w_pc=%h m_ready=%b need 1 %h 1",
               w_valid, w_pc, m_ready, pb);
    end
    tick();
    checks++;
    if (w_valid !== 1'b0 || retire_cnt !== cnt || cnt !== 32'd3) begin
      errors++;
      $display("FAIL order_end: valid=%b cnt=%0d need 0 3", w_valid, retire_cnt);
    end
  endtask

  task automatic test_flush();
    w_ready = 0; m_valid = 1;
    rand_in(); tick();
    rand_in(); tick();
    req = 1; w_ready = 1;
    rand_in();
    tick();
    req = 0; m_valid = 0;
    checks++;
    if (w_valid !== 1'b0 || m_ready !== 1'b1 || w_regwrite !== 1'b0) begin
      errors++;
      $display("FAIL flush: valid=%b m_ready=%b rw=%b need 0 1 0",
               w_valid, m_ready, w_regwrite);
    end
    checks++;
    if (retire_cnt !== 32'd3) begin
      errors++;
      $display("FAIL flush_cnt: cnt=%0d need 3", retire_cnt);
    end
  endtask

  task automatic test_zero();
    w_ready = 0; m_valid = 1;
    rand_in();
    m_wdsel = 1; m_result = 32'h1234; m_a3 = 0; m_regwrite = 1;
    tick();
    m_valid = 0;
    checks++;
    if (w_valid !== 1'b1 || w_regwrite !== 1'b0 || fwd_a3 !== 5'd0 ||
        w_wd !== 32'h1234) begin
      errors++;
      $display("FAIL zero_reg: valid=%b rw=%b fwd_a3=%0d wd=%h need 1 0 0 1234",
               w_valid, w_regwrite, fwd_a3, w_wd);
    end
    w_ready = 1;
    tick();
    checks++;
    if (retire_cnt !== 32'd4 || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_cnt: cnt=%0d valid=%b need 4 0", retire_cnt, w_valid);
    end
  endtask

  task automatic test_reset_mid();
    w_ready = 0; m_valid = 1;
    rand_in(); tick();
    rand_in(); tick();
    #2 reset = 1'b0;
    #1;
    q.delete(); cnt = 0;
    checks++;
    if (w_valid !== 1'b0 || m_ready !== 1'b1 || retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b m_ready=%b cnt=%0d need 0 1 0",
               w_valid, m_ready, retire_cnt);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    m_valid = 1; w_ready = 0;
    rand_in();
    tick();
    m_valid = 0;
    checks++;
    if (w_valid !== 1'b1 || w_wd !== q[0].wd) begin
      errors++;
      $display("FAIL rst_accept: valid=%b wd=%h need 1 %h", w_valid, w_wd, q[0].wd);
    end
  endtask

  task automatic test_random();
    logic exp_rw;
    for (int i = 0; i < 10000; i++) begin
      m_valid = 1'($urandom);
      w_ready = ($urandom_range(0, 3) != 0);
      req     = ($urandom_range(0, 63) == 0);
      rand_in();
      checks++;
      if (w_valid !== (q.size() > 0) || m_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rnd_occ@%0d: valid=%b m_ready=%b need occ %0d",
                 i, w_valid, m_ready, q.size());
      end
      checks++;
      if (retire_cnt !== cnt) begin
        errors++;
        $display("FAIL rnd_cnt@%0d: cnt=%0d need %0d", i, retire_cnt, cnt);
      end
      if (q.size() > 0) begin
        exp_rw = q[0].rw && (q[0].a3 != 0);
        checks++;
        if (w_wd !== q[0].wd || fwd_data !== q[0].wd || w_pc !== q[0].pc ||
            w_op !== q[0].op || w_a3 !== q[0].a3) begin
          errors++;
          $display("FAIL rnd_data@%0d: wd=%h pc=%h op=%h a3=%0d need %h %h %h %0d",
                   i, w_wd, w_pc, w_op, w_a3, q[0].wd, q[0].pc, q[0].op, q[0].a3);
        end
        checks++;
        if (w_regwrite !== exp_rw || fwd_a3 !== (exp_rw ? q[0].a3 : 5'd0)) begin
          errors++;
          $display("FAIL rnd_rw@%0d: rw=%b fwd_a3=%0d need %b", i,
                   w_regwrite, fwd_a3, exp_rw);
        end
      end
      tick();
    end
    req = 0; m_valid = 0; w_ready = 1;
    tick(); tick();
    checks++;
    if (w_valid !== 1'b0 || retire_cnt !== cnt) begin
      errors++;
      $display("FAIL rnd_drain: valid=%b cnt=%0d need 0 %0d", w_valid, retire_cnt, cnt);
    end
  endtask

  initial begin
    test_reset_state();
    test_link();
    test_order();
    test_flush();
    test_zero();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
